uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter (start bit, WIDTH data bits LSB first, STOP_BITS stop bits).
//
// Ports
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous reset, active high
//   o_rd_en     : one-cycle read request to the upstream FIFO
//   i_rd_data   : FIFO read data (WIDTH bits)
//   i_rd_valid  : i_rd_data valid, one cycle after o_rd_en
//   i_empty     : FIFO holds no data
//   i_cts       : clear-to-send, sampled only while idle
//   o_tx        : serial line, idle high
//   o_busy      : high whenever not idle
//   o_tx_done   : one-cycle pulse on the final stop-bit cycle
//
// Every output is a flop loaded from the next-state decode, so each output
// is aligned with the state it belongs to and the serial line is glitch-free.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_rd_en,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic             i_rd_valid,
  input  logic             i_empty,
  input  logic             i_cts,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [WIDTH-1:0]  r_shift;
  logic              r_fetch_miss;
  logic              r_tx;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_tx_done;

  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic              w_miss_nxt;
  logic              w_tx_nxt;
  logic              w_rd_en_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_baud_last;

  assign w_baud_last = (r_baud == BAUD_LAST);

  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_fetch_miss <= 1'b0;
      r_tx         <= 1'b1;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_baud       <= w_baud_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_fetch_miss <= w_miss_nxt;
      r_tx         <= w_tx_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_busy       <= w_busy_nxt;
      r_tx_done    <= w_done_nxt;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_miss_nxt  = r_fetch_miss;
    w_rd_en_nxt = 1'b0;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!i_empty && i_cts) begin
          w_state_nxt = S_FETCH;
          w_rd_en_nxt = 1'b1;
          w_miss_nxt  = 1'b0;
        end
      end

      // The read request is on the line during the first FETCH cycle, so
      // valid normally lands in the second; two misses in a row give up.
      S_FETCH: begin
        if (i_rd_valid) begin
          w_shift_nxt = i_rd_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_miss_nxt  = 1'b0;
          w_state_nxt = S_START;
        end else if (r_fetch_miss) begin
          w_miss_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_miss_nxt  = 1'b1;
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == DATA_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end

      // Bit index is reused to count stop bits
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit_idx == STOP_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt   = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so the flops track it
    if (w_state_nxt == S_START) begin
      w_tx_nxt = 1'b0;
    end else if (w_state_nxt == S_DATA) begin
      w_tx_nxt = w_shift_nxt[0];
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST) &&
                 (w_bit_nxt == STOP_LAST);
  end

  assign o_tx      = r_tx;
  assign o_rd_en   = r_rd_en;
  assign o_busy    = r_busy;
  assign o_tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=4, WIDTH=8, and
// instances for one and two stop bits, each fed by a small FIFO model.
module tb_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned W   = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_cts = 1'b1;

  logic         o_rd_en;
  logic [W-1:0] i_rd_data = '0;
  logic         i_rd_valid = 1'b0;
  logic         i_empty = 1'b1;
  logic         o_tx;
  logic         o_busy;
  logic         o_tx_done;

  logic         o_rd_en2;
  logic [W-1:0] i_rd_data2 = '0;
  logic         i_rd_valid2 = 1'b0;
  logic         i_empty2 = 1'b1;
  logic         o_tx2;
  logic         o_busy2;
  logic         o_tx_done2;

  int errs    = 0;
  int checks  = 0;
  int n_rd    = 0;
  int rd_viol = 0;

  logic prev_rd = 1'b0;
  logic pend_a  = 1'b0;
  logic pend_b  = 1'b0;
  logic stall_a = 1'b0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 i_clk = ~i_clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(W), .STOP_BITS(1)) u_dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_rd_en    (o_rd_en),
    .i_rd_data  (i_rd_data),
    .i_rd_valid (i_rd_valid),
    .i_empty    (i_empty),
    .i_cts      (i_cts),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_tx_done  (o_tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(W), .STOP_BITS(2)) u_dut2 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_rd_en    (o_rd_en2),
    .i_rd_data  (i_rd_data2),
    .i_rd_valid (i_rd_valid2),
    .i_empty    (i_empty2),
    .i_cts      (i_cts),
    .o_tx       (o_tx2),
    .o_busy     (o_busy2),
    .o_tx_done  (o_tx_done2)
  );

  // FIFO model A: data valid one cycle after o_rd_en; stall_a withholds it
  always @(negedge i_clk) begin
    i_rd_valid = 1'b0;
    if (pend_a && !stall_a && q_a.size() > 0) begin
      i_rd_valid = 1'b1;
      i_rd_data  = q_a.pop_front();
    end
    if (o_rd_en === 1'b1) begin
      n_rd++;
      if (prev_rd || i_empty) rd_viol++;
    end
    prev_rd = (o_rd_en === 1'b1);
    pend_a  = (o_rd_en === 1'b1);
    i_empty = (q_a.size() == 0);
  end

  // FIFO model B
  always @(negedge i_clk) begin
    i_rd_valid2 = 1'b0;
    if (pend_b && q_b.size() > 0) begin
      i_rd_valid2 = 1'b1;
      i_rd_data2  = q_b.pop_front();
    end
    pend_b   = (o_rd_en2 === 1'b1);
    i_empty2 = (q_b.size() == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic tx_of(input bit sel);
    return sel ? o_tx2 : o_tx;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? o_busy2 : o_busy;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? o_tx_done2 : o_tx_done;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then checks every cycle of the frame against d
  task automatic check_frame(input string tag, input bit sel, input logic [7:0] d,
                             input int stops, output logic [10:0] cap, output int done_at);
    int   n;
    int   nbits;
    int   tx_bad;
    int   busy_bad;
    int   done_bad;
    logic e;
    cap      = '0;
    done_at  = 0;
    n        = 0;
    busy_bad = 0;
    done_bad = 0;
    nbits    = 1 + int'(W) + stops;
    while (tx_of(sel) !== 1'b0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_start_seen"}, 32'(n < 200), 32'd1);
    if (n >= 200) return;
    for (int b = 0; b < nbits; b++) begin
      e = (b == 0) ? 1'b0 : (b <= int'(W)) ? d[b-1] : 1'b1;
      tx_bad = 0;
      for (int k = 0; k < int'(CPB); k++) begin
        if (b != 0 || k != 0) @(negedge i_clk);
        if (tx_of(sel) !== e) tx_bad++;
        if (k == int'(CPB) / 2) cap[b] = tx_of(sel);
        if (busy_of(sel) !== 1'b1) busy_bad++;
        if (done_of(sel) === 1'b1) begin
          if (done_at == 0) done_at = b * int'(CPB) + k + 1;
          else done_bad++;
        end
      end
      chk($sformatf("%s_bit%0d", tag, b), tx_bad, 0);
    end
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_done_once"}, done_bad, 0);
  endtask

  // Idle-high cycles between the last stop cycle and the next start bit
  task automatic measure_gap(output int g);
    g = 0;
    @(negedge i_clk);
    while (o_tx !== 1'b0 && g < 100) begin
      g++;
      @(negedge i_clk);
    end
  endtask

  initial begin
    logic [10:0] cap;
    int          dat;
    int          g;
    int          rd0;
    int          bad;
    int          idle_seen;
    int          n;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_tx_done, 0);
    chk("rst_tx2", o_tx2, 1);
    i_rst = 1'b0;

    // Empty FIFO for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_rd_en !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    chk("empty_idle", bad, 0);

    // Single byte 0x61
    rd0 = n_rd;
    q_a.push_back(8'h61);
    check_frame("b61", 1'b0, 8'h61, 1, cap, dat);
    chk("b61_cap", 32'(cap[9:0]), 32'(10'b1011000010));
    chk("b61_done_at", dat, 40);
    repeat (10) @(negedge i_clk);
    chk("b61_rd_pulses", n_rd - rd0, 1);

    // Back-to-back 0x41, 0x7A
    rd0 = n_rd;
    q_a.push_back(8'h41);
    q_a.push_back(8'h7A);
    check_frame("b41", 1'b0, 8'h41, 1, cap, dat);
    chk("b41_cap", 32'(cap[9:0]), 32'(10'b1010000010));
    measure_gap(g);
    chk("b2b_gap", g, 3);
    check_frame("b7a", 1'b0, 8'h7A, 1, cap, dat);
    chk("b7a_done_at", dat, 40);
    repeat (10) @(negedge i_clk);
    chk("b2b_rd_pulses", n_rd - rd0, 2);

    // FIFO never answers: retries from idle, line stays high, byte kept
    stall_a = 1'b1;
    rd0 = n_rd;
    q_a.push_back(8'hC3);
    bad = 0;
    idle_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) bad++;
      if (o_busy === 1'b0) idle_seen++;
    end
    chk("stall_tx_high", bad, 0);
    chk("stall_returns_idle", 32'(idle_seen >= 5), 32'd1);
    chk("stall_retries", 32'(n_rd - rd0 >= 3), 32'd1);
    stall_a = 1'b0;
    check_frame("bc3", 1'b0, 8'hC3, 1, cap, dat);
    repeat (10) @(negedge i_clk);

    // Flow control
    i_cts = 1'b0;
    rd0 = n_rd;
    q_a.push_back(8'h3C);
    repeat (10) @(negedge i_clk);
    chk("cts_block_rd", n_rd - rd0, 0);
    chk("cts_block_busy", o_busy, 0);
    i_cts = 1'b1;
    @(negedge i_clk);
    chk("cts_rd_next_edge", o_rd_en, 1);
    fork
      check_frame("b3c", 1'b0, 8'h3C, 1, cap, dat);
      begin
        repeat (12) @(negedge i_clk);
        i_cts = 1'b0;
      end
    join
    chk("b3c_done_at", dat, 40);
    i_cts = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("cts_rd_pulses", n_rd - rd0, 1);

    // Reset during data bit 3 of 0x55, then 0xA5 goes out whole
    q_a.push_back(8'h55);
    q_a.push_back(8'hA5);
    n = 0;
    while (o_tx !== 1'b0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("b55_start_seen", 32'(n < 100), 32'd1);
    repeat (18) @(negedge i_clk);
    chk("b55_bit3_low", o_tx, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_tx", o_tx, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_rd_en", o_rd_en, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_frame("ba5", 1'b0, 8'hA5, 1, cap, dat);
    chk("ba5_done_at", dat, 40);

    // Two stop bits, 0xFF
    q_b.push_back(8'hFF);
    check_frame("bff2", 1'b1, 8'hFF, 2, cap, dat);
    chk("bff2_cap", 32'(cap), 32'(11'b11111111110));
    chk("bff2_done_at", dat, 44);

    repeat (10) @(negedge i_clk);
    chk("rd_protocol", rd_viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
